// File: rtl/mem_port_arb_if.sv
// Request/response and memory-port bundle shared between mem_port_arb and its requesters.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arb_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 80,
    parameter int AW    = 6
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_data;
    logic [AW-1:0]         mem_raddr;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_wen;
    logic [AW-1:0]         mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one write port + async read port memory between NREQ single-word requesters.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_port_arb #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 80,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    (* remu_clock *) input logic clk,
    input  logic                 rst_n,
    mem_port_arb_if.slave        bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   start;
    logic             hs;

    logic             op_vld;
    logic             op_write;
    logic [AW-1:0]    op_addr;
    logic [WIDTH-1:0] op_wdata;
    logic [IDW-1:0]   op_id;

    logic [NREQ-1:0]  resp_valid_r;
    logic [WIDTH-1:0] resp_data_r;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) sum -= NREQ;
        return IDW'(sum);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        return NREQ'(1) << id;
    endfunction

`ifdef MEM_PORT_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // The requester after the last winner becomes highest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    // Grant stage: first valid requester scanning upward from start.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == '0 && bus.req_valid[rr_index(start, k)]) begin
                grant[rr_index(start, k)] = 1'b1;
                gnt_id                    = rr_index(start, k);
            end
        end
    end

    assign bus.req_ready = grant & {NREQ{rst_n}};
    assign hs            = rst_n & (|grant);

    // Op stage: the accepted request owns the memory ports for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_vld   <= 1'b0;
            op_write <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            op_id    <= '0;
        end else begin
            op_vld <= hs;
            if (hs) begin
                op_write <= bus.req_write[gnt_id];
                op_addr  <= bus.req_addr[gnt_id*AW +: AW];
                op_wdata <= bus.req_wdata[gnt_id*WIDTH +: WIDTH];
                op_id    <= gnt_id;
            end
        end
    end

    // Gating with rst_n drops the write of an op caught by reset.
    assign bus.mem_raddr = op_addr;
    assign bus.mem_waddr = op_addr;
    assign bus.mem_wdata = op_wdata;
    assign bus.mem_wen   = op_vld & op_write & rst_n;

    // Response stage: writes keep the previous read data and act as an acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_r <= '0;
            resp_data_r  <= '0;
        end else begin
            resp_valid_r <= op_vld ? onehot(op_id) : '0;
            if (op_vld && !op_write) begin
                resp_data_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios, then randomized traffic,
// checked against a transaction-level model of arbitration, memory and response timing.
module tb_mem_port_arb;
    localparam int NREQ  = 2;
    localparam int WIDTH = 80;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

    mem_port_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [WIDTH-1:0] init_word(input int i);
        return {16'hBEEF ^ 16'(i), 64'h0123_4567_89AB_CDEF + 64'(i)};
    endfunction

    // Memory instance behaviour: loaded on the first edge, async read.
    logic [WIDTH-1:0] mem_arr [DEPTH];
    logic             mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_wen) begin
            mem_arr[bus.mem_waddr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem_arr[bus.mem_raddr];

    typedef struct {
        int               t;
        int               id;
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } txn_t;

    txn_t             q[$];
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] exp_rdata;
    int               cyc;
    int               ptr_m;
    int               last_win;
    int               gcnt [NREQ];
    int               rcnt [NREQ];
    int               checks;
    int               failures;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
`ifdef MEM_PORT_ARB_RR_EN
            int i = (p + k) % NREQ;
`else
            int i = k;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check grant, take the edge, update the model, check outputs.
    task automatic step(input logic rst_v, input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                        input logic [NREQ*AW-1:0] a, input logic [NREQ*WIDTH-1:0] d);
        int              win;
        txn_t            tx;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        rst_n         = rst_v;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #3;
        win       = rst_v ? pick(v, ptr_m) : -1;
        exp_ready = (win >= 0) ? (NREQ'(1) << win) : '0;
        check("req_ready", bus.req_ready, exp_ready);
        @(posedge clk);
        cyc++;
        exp_rv   = '0;
        last_win = -1;
        if (!rst_v) begin
            q.delete();
            exp_rdata = '0;
            ptr_m     = 0;
        end else begin
            if (q.size() > 0 && q[0].t == cyc - 1) begin
                tx = q.pop_front();
                if (tx.wr) model_mem[tx.addr] = tx.wdata;
                else       exp_rdata = model_mem[tx.addr];
                exp_rv[tx.id] = 1'b1;
            end
            if (win >= 0) begin
                tx.t     = cyc;
                tx.id    = win;
                tx.wr    = w[win];
                tx.addr  = a[win*AW +: AW];
                tx.wdata = d[win*WIDTH +: WIDTH];
                q.push_back(tx);
                ptr_m    = (win + 1) % NREQ;
                last_win = win;
                gcnt[win]++;
            end
        end
        #1;
        check("resp_valid", bus.resp_valid, exp_rv);
        check("resp_data", bus.resp_data, exp_rdata);
        for (int i = 0; i < NREQ; i++) if (bus.resp_valid[i]) rcnt[i]++;
        if (q.size() > 0 && q[$].t == cyc) begin
            check("mem_wen", bus.mem_wen, q[$].wr);
            check("mem_waddr", bus.mem_waddr, q[$].addr);
            check("mem_raddr", bus.mem_raddr, q[$].addr);
            if (q[$].wr) check("mem_wdata", bus.mem_wdata, q[$].wdata);
        end else begin
            check("mem_wen_idle", bus.mem_wen, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0);
    endtask

    logic [NREQ-1:0]       pv, pw;
    logic [NREQ*AW-1:0]    pa;
    logic [NREQ*WIDTH-1:0] pd;
    logic [WIDTH-1:0]      v80;

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        ptr_m     = 0;
        last_win  = -1;
        exp_rdata = '0;
        gcnt      = '{default: 0};
        rcnt      = '{default: 0};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

        // Reset with requests pending, then idle.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b11, {6'd9, 6'd4}, {NREQ*WIDTH{1'b1}});
        check("rst_mem_waddr", bus.mem_waddr, 6'd0);
        check("rst_mem_wdata", bus.mem_wdata, 80'd0);
        idle(5);

        // Single write then read back from the other requester.
        v80 = 80'h1234_5678_9ABC_DEF0_1111;
        step(1'b1, 2'b01, 2'b01, {6'd0, 6'd5}, {80'd0, v80});
        check("wr_mem_wen", bus.mem_wen, 1'b1);
        check("wr_mem_waddr", bus.mem_waddr, 6'd5);
        idle(1);
        check("wr_ack", bus.resp_valid, 2'b01);
        step(1'b1, 2'b10, 2'b00, {6'd5, 6'd0}, '0);
        idle(1);
        check("rd_resp_valid", bus.resp_valid, 2'b10);
        check("rd_resp_data", bus.resp_data, v80);

        // Back-to-back read-after-write at the top address.
        step(1'b1, 2'b01, 2'b01, {6'd0, 6'd63}, {80'd0, {WIDTH{1'b1}}});
        step(1'b1, 2'b10, 2'b00, {6'd63, 6'd0}, '0);
        idle(1);
        check("raw_resp_valid", bus.resp_valid, 2'b10);
        check("raw_resp_data", bus.resp_data, {WIDTH{1'b1}});
        idle(1);

        // Contention: both requesters hold reads.
        gcnt = '{default: 0};
        rcnt = '{default: 0};
        for (int i = 0; i < 6; i++) step(1'b1, 2'b11, 2'b00, {6'd2, 6'd1}, '0);
`ifdef MEM_PORT_ARB_RR_EN
        check("rr_grants0", gcnt[0], 3);
        idle(2);
        check("rr_resp0", rcnt[0], 3);
        check("rr_resp1", rcnt[1], 3);
`else
        check("fp_grants0", gcnt[0], 6);
        check("fp_grants1", gcnt[1], 0);
        step(1'b1, 2'b10, 2'b00, {6'd2, 6'd1}, '0);
        check("fp_release", last_win, 1);
        idle(2);
        check("fp_resp0", rcnt[0], 6);
        check("fp_resp1", rcnt[1], 1);
`endif

        // Reset arriving while a write is in its op cycle.
        step(1'b1, 2'b01, 2'b01, {6'd0, 6'd10}, {80'd0, 80'hDEAD_BEEF_0000_5555_AAAA});
        step(1'b0, 2'b00, 2'b00, '0, '0);
        check("midrst_no_resp", bus.resp_valid, 2'b00);
        idle(1);
        step(1'b1, 2'b10, 2'b00, {6'd10, 6'd0}, '0);
        idle(1);
        check("midrst_resp_valid", bus.resp_valid, 2'b10);
        check("midrst_data", bus.resp_data, init_word(10));

        // Randomized traffic with withdrawals and occasional resets.
        pv = '0; pw = '0; pa = '0; pd = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && $urandom_range(0, 9) == 0) pv[i] = 1'b0;
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pw[i] = 1'($urandom_range(0, 1));
                    pa[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 6'd63 : AW'($urandom_range(0, 7));
                    pd[i*WIDTH +: WIDTH] = WIDTH'({$urandom, $urandom, $urandom});
                end
            end
            step(($urandom_range(0, 63) != 0), pv, pw, pa, pd);
            if (last_win >= 0) pv[last_win] = 1'b0;
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
